// File: rtl/sid_write_scheduler.sv
// Merges two command streams into one paced SID register-write port, one write per ce_1m slot.
// Optional macro SIDSCHED_DELAY_CMD_EN turns DELAY_CMD entries into timed idle periods.
module sid_write_scheduler #(
  parameter int         DEPTH     = 8,
  parameter logic [4:0] DELAY_CMD = 5'h1F
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce_1m,
  input  logic                     a_valid,
  input  logic [4:0]               a_addr,
  input  logic [7:0]               a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [4:0]               b_addr,
  input  logic [7:0]               b_data,
  output logic                     b_ready,
  output logic                     sid_we,
  output logic [4:0]               sid_addr,
  output logic [7:0]               sid_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [12:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic          prefer_a_reg;
  logic          sid_we_reg;
  logic [4:0]    sid_addr_reg;
  logic [7:0]    sid_data_reg;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [12:0]   push_word;
  logic [4:0]    head_addr;
  logic [7:0]    head_data;
  logic          head_is_delay;

  assign full  = (level_reg == FULL_LEVEL);
  assign empty = (level_reg == '0);

  // Fullness is judged on the registered level, so a same-cycle pop never frees a slot early.
  assign a_ready   = !full && a_valid && (!b_valid || prefer_a_reg);
  assign b_ready   = !full && b_valid && (!a_valid || !prefer_a_reg);
  assign push      = a_ready || b_ready;
  assign push_word = a_ready ? {a_addr, a_data} : {b_addr, b_data};

  // Head is read asynchronously so an entry pushed one clk before ce_1m can issue at it.
  assign head_addr     = mem[rd_ptr_reg][12:8];
  assign head_data     = mem[rd_ptr_reg][7:0];
  assign head_is_delay = (head_addr == DELAY_CMD);

`ifdef SIDSCHED_DELAY_CMD_EN
  logic [7:0] wait_cnt_reg;

  assign pop  = ce_1m && !empty && (wait_cnt_reg == 8'd0);
  assign busy = !empty || (wait_cnt_reg != 8'd0) || sid_we_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_reg <= 8'd0;
    end else if (ce_1m) begin
      if (wait_cnt_reg != 8'd0)
        wait_cnt_reg <= wait_cnt_reg - 8'd1;
      else if (!empty && head_is_delay)
        wait_cnt_reg <= head_data;
    end
  end
`else
  assign pop  = ce_1m && !empty;
  assign busy = !empty || sid_we_reg;
`endif

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      prefer_a_reg <= 1'b1;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      if (a_ready)
        prefer_a_reg <= 1'b0;
      else if (b_ready)
        prefer_a_reg <= 1'b1;
    end
  end

  // SID outputs only move on ce_1m edges; delay entries are consumed without a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      sid_we_reg   <= 1'b0;
      sid_addr_reg <= 5'd0;
      sid_data_reg <= 8'd0;
    end else if (ce_1m) begin
      if (pop && !head_is_delay) begin
        sid_we_reg   <= 1'b1;
        sid_addr_reg <= head_addr;
        sid_data_reg <= head_data;
      end else begin
        sid_we_reg   <= 1'b0;
      end
    end
  end

  assign sid_we     = sid_we_reg;
  assign sid_addr   = sid_addr_reg;
  assign sid_data   = sid_data_reg;
  assign fifo_level = level_reg;

endmodule

// File: tb/tb_sid_write_scheduler.sv
// Bench for sid_write_scheduler: vector table, corner-case sequences and a random run
// checked against a queue-based model of the scheduling rules.
module tb_sid_write_scheduler;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce_1m = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_ready, b_ready, sid_we, busy;
  logic [4:0] sid_addr;
  logic [7:0] sid_data;
  logic [3:0] fifo_level;

  sid_write_scheduler #(.DEPTH(DEPTH), .DELAY_CMD(5'h1F)) dut (
    .clk(clk), .reset(reset), .ce_1m(ce_1m),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .sid_we(sid_we), .sid_addr(sid_addr), .sid_data(sid_data),
    .fifo_level(fifo_level), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic [12:0] mq[$];
  bit          m_pref_a;
  int          m_wait;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [7:0]  m_data;

  logic s_ar, s_br;

  typedef struct {
    bit ce; bit av; logic [4:0] aa; logic [7:0] ad; bit bv; logic [4:0] ba; logic [7:0] bd;
    bit ear; bit ebr; bit ewe; logic [4:0] eaddr; logic [7:0] edata; logic [3:0] elev; bit ebusy;
  } vec_t;
  vec_t tbl[17];

  function automatic vec_t mkv(bit ce, bit av, logic [4:0] aa, logic [7:0] ad,
                               bit bv, logic [4:0] ba, logic [7:0] bd,
                               bit ear, bit ebr, bit ewe, logic [4:0] eaddr,
                               logic [7:0] edata, logic [3:0] elev, bit ebusy);
    vec_t v;
    v.ce = ce; v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.ear = ear; v.ebr = ebr; v.ewe = ewe; v.eaddr = eaddr; v.edata = edata;
    v.elev = elev; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h required %0h", name, got, want);
  endtask

  task automatic model_reset();
    mq.delete();
    m_pref_a = 1'b1;
    m_wait   = 0;
    m_we     = 1'b0;
    m_addr   = 5'd0;
    m_data   = 8'd0;
  endtask

  // One clk: drive, check readies mid-cycle, clock, advance model, check registered outputs.
  task automatic step(input bit ce, input bit av, input logic [4:0] aa, input logic [7:0] ad,
                      input bit bv, input logic [4:0] ba, input logic [7:0] bd);
    bit full, ga, gb, m_busy;
    logic [12:0] head;
    ce_1m = ce; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    full = (mq.size() >= DEPTH);
    ga = !full && av && (!bv || m_pref_a);
    gb = !full && bv && (!av || !m_pref_a);
    @(negedge clk);
    s_ar = a_ready;
    s_br = b_ready;
    check("ready", {30'd0, s_ar, s_br}, {30'd0, ga, gb});
    @(posedge clk);
    #1;
    if (reset) begin
      model_reset();
    end else begin
      if (ce) begin
`ifdef SIDSCHED_DELAY_CMD_EN
        if (m_wait != 0) begin
          m_wait--;
          m_we = 1'b0;
        end else
`endif
        if (mq.size() != 0) begin
          head = mq.pop_front();
          if (head[12:8] == 5'h1F) begin
`ifdef SIDSCHED_DELAY_CMD_EN
            m_wait = int'(head[7:0]);
`endif
            m_we = 1'b0;
          end else begin
            m_we = 1'b1; m_addr = head[12:8]; m_data = head[7:0];
          end
        end else begin
          m_we = 1'b0;
        end
      end
      if (ga) begin mq.push_back({aa, ad}); m_pref_a = 1'b0; end
      else if (gb) begin mq.push_back({ba, bd}); m_pref_a = 1'b1; end
    end
    m_busy = (mq.size() != 0) || (m_wait != 0) || m_we;
    check("outputs", {11'd0, sid_we, sid_addr, sid_data, fifo_level, busy},
          {11'd0, m_we, m_addr, m_data, 4'(mq.size()), m_busy});
    if (ce && sid_we)
      $display("write addr=%h data=%h level=%0d", sid_addr, sid_data, fifo_level);
  endtask

  task automatic idle(input bit ce);
    step(ce, 1'b0, 5'd0, 8'd0, 1'b0, 5'd0, 8'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(1'b0);
    reset = 1'b0;
  endtask

  task automatic slots(input int n);
    for (int s = 0; s < n; s++) begin
      idle(1'b1);
      for (int k = 0; k < 11; k++) idle(1'b0);
    end
  endtask

  initial begin
    int zeros;
    bit found, any_we;
    bit ce, av, bv;
    logic [4:0] aa, ba;
    logic [7:0] ad, bd;

    model_reset();
    do_reset();
    check("reset_state", {sid_we, sid_addr, sid_data, fifo_level, busy}, 19'd0);

    // Table: single push, alternation, push on ce, arbitration, delay D=0
    tbl[0]  = mkv(0,1,5'h18,8'h0F,0,5'h00,8'h00, 1,0,0,5'h00,8'h00,4'd1,1);
    tbl[1]  = mkv(1,0,5'h00,8'h00,0,5'h00,8'h00, 0,0,1,5'h18,8'h0F,4'd0,1);
    tbl[2]  = mkv(0,0,5'h00,8'h00,0,5'h00,8'h00, 0,0,1,5'h18,8'h0F,4'd0,1);
    tbl[3]  = mkv(1,0,5'h00,8'h00,0,5'h00,8'h00, 0,0,0,5'h18,8'h0F,4'd0,0);
    tbl[4]  = mkv(0,0,5'h00,8'h00,1,5'h05,8'h55, 0,1,0,5'h18,8'h0F,4'd1,1);
    tbl[5]  = mkv(1,1,5'h06,8'h66,0,5'h00,8'h00, 1,0,1,5'h05,8'h55,4'd1,1);
    tbl[6]  = mkv(1,0,5'h00,8'h00,0,5'h00,8'h00, 0,0,1,5'h06,8'h66,4'd0,1);
    tbl[7]  = mkv(1,0,5'h00,8'h00,0,5'h00,8'h00, 0,0,0,5'h06,8'h66,4'd0,0);
    tbl[8]  = mkv(0,1,5'h07,8'h77,1,5'h08,8'h88, 0,1,0,5'h06,8'h66,4'd1,1);
    tbl[9]  = mkv(0,1,5'h07,8'h77,1,5'h08,8'h88, 1,0,0,5'h06,8'h66,4'd2,1);
    tbl[10] = mkv(1,0,5'h00,8'h00,0,5'h00,8'h00, 0,0,1,5'h08,8'h88,4'd1,1);
    tbl[11] = mkv(1,0,5'h00,8'h00,0,5'h00,8'h00, 0,0,1,5'h07,8'h77,4'd0,1);
    tbl[12] = mkv(1,0,5'h00,8'h00,0,5'h00,8'h00, 0,0,0,5'h07,8'h77,4'd0,0);
    tbl[13] = mkv(0,1,5'h1F,8'h00,0,5'h00,8'h00, 1,0,0,5'h07,8'h77,4'd1,1);
    tbl[14] = mkv(1,0,5'h00,8'h00,0,5'h00,8'h00, 0,0,0,5'h07,8'h77,4'd0,0);
    tbl[15] = mkv(0,1,5'h00,8'h00,0,5'h00,8'h00, 1,0,0,5'h07,8'h77,4'd1,1);
    tbl[16] = mkv(1,0,5'h00,8'h00,0,5'h00,8'h00, 0,0,1,5'h00,8'hAA,4'd0,1);
    tbl[15].ad = 8'hAA;
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].ce, tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd);
      check($sformatf("vec%0d", i),
            {11'd0, s_ar, s_br, sid_we, sid_addr, sid_data, fifo_level, busy},
            {11'd0, tbl[i].ear, tbl[i].ebr, tbl[i].ewe, tbl[i].eaddr, tbl[i].edata,
             tbl[i].elev, tbl[i].ebusy});
    end

    // Full FIFO: readies drop, ce in the same clk does not free a slot for that clk
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 5'(i), 8'(8'h40 + i), 1'b0, 5'd0, 8'd0);
    check("full_level", 32'(fifo_level), 32'd8);
    step(1'b0, 1'b1, 5'h0A, 8'h01, 1'b1, 5'h0B, 8'h02);
    check("full_readies", {30'd0, s_ar, s_br}, 32'd0);
    step(1'b1, 1'b1, 5'h0A, 8'h03, 1'b0, 5'd0, 8'd0);
    check("full_pop_no_push", {27'd0, s_ar, fifo_level}, 32'd7);
    step(1'b0, 1'b1, 5'h0A, 8'h04, 1'b0, 5'd0, 8'd0);
    check("push_after_pop", {27'd0, s_ar, fifo_level}, {27'd0, 1'b1, 4'd8});
    slots(9);

    // Delay command {1F,03} followed by a write
    do_reset();
    step(1'b0, 1'b1, 5'h1F, 8'h03, 1'b0, 5'd0, 8'd0);
    step(1'b0, 1'b1, 5'h00, 8'hAA, 1'b0, 5'd0, 8'd0);
    zeros = 0;
    found = 1'b0;
    for (int s = 0; s < 10 && !found; s++) begin
      for (int k = 0; k < 11; k++) idle(1'b0);
      idle(1'b1);
      if (sid_we) found = 1'b1;
      else zeros++;
    end
    check("delay_write_seen", {31'd0, found}, 32'd1);
`ifdef SIDSCHED_DELAY_CMD_EN
    check("delay_idle_slots", 32'(zeros), 32'd4);
`else
    check("delay_idle_slots", 32'(zeros), 32'd1);
`endif
    check("delay_write_value", {19'd0, sid_addr, sid_data}, {19'd0, 5'h00, 8'hAA});
    slots(1);

    // Reset while a delay is counting down with entries queued
    do_reset();
    step(1'b0, 1'b1, 5'h1F, 8'h03, 1'b0, 5'd0, 8'd0);
    step(1'b0, 1'b1, 5'h01, 8'h11, 1'b0, 5'd0, 8'd0);
    step(1'b0, 1'b1, 5'h02, 8'h22, 1'b0, 5'd0, 8'd0);
    step(1'b0, 1'b1, 5'h03, 8'h33, 1'b0, 5'd0, 8'd0);
    slots(2);
    do_reset();
    check("midreset_state", {27'd0, fifo_level, sid_we, busy}, 32'd0);
    any_we = 1'b0;
    for (int s = 0; s < 6; s++) begin
      slots(1);
      if (sid_we) any_we = 1'b1;
    end
    check("midreset_no_writes", {31'd0, any_we}, 32'd0);

    // Push on a ce clk with the FIFO empty issues one SID cycle later
    do_reset();
    step(1'b1, 1'b1, 5'h0A, 8'hBB, 1'b0, 5'd0, 8'd0);
    check("push_on_ce_not_seen", {31'd0, sid_we}, 32'd0);
    for (int k = 0; k < 11; k++) idle(1'b0);
    idle(1'b1);
    check("push_on_ce_issue", {18'd0, sid_we, sid_addr, sid_data}, {18'd0, 1'b1, 5'h0A, 8'hBB});

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 900; i++) begin
      ce = (i % 12 == 0);
      av = ($urandom_range(0, 9) < 4);
      bv = ($urandom_range(0, 9) < 4);
      aa = ($urandom_range(0, 7) == 0) ? 5'h1F : 5'($urandom_range(0, 30));
      ba = ($urandom_range(0, 7) == 0) ? 5'h1F : 5'($urandom_range(0, 30));
      ad = (aa == 5'h1F) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      bd = (ba == 5'h1F) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      step(ce, av, aa, ad, bv, ba, bd);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sid_write_scheduler.md
Name: sid_write_scheduler

Overview:
- Shares the single sid8580 register-write port between two command sources, A and B. Typical sources: the ROM player and a host/UART command path.
- Buffers commands in a small FIFO and issues at most one write per 1 MHz SID cycle, aligned to ce_1m.
- Interprets addr 5'h1F as a delay command.
- Sits between the command sources and the SID core's we/addr/data_in inputs.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2.
DELAY_CMD, 5'h1F, address code treated as a delay command.

Ports:
clk  in  1  system clock (12 MHz)
reset  in  1  synchronous, active-high reset
ce_1m  in  1  one-clk strobe marking each SID cycle
a_valid  in  1  requester A has a command
a_addr  in  5  requester A register address / command code
a_data  in  8  requester A register value / delay count
a_ready  out  1  A command accepted this cycle
b_valid  in  1  requester B has a command
b_addr  in  5  requester B address
b_data  in  8  requester B data
b_ready  out  1  B command accepted this cycle
sid_we  out  1  write enable to SID
sid_addr  out  5  SID register address
sid_data  out  8  SID register value
fifo_level  out  log2(DEPTH)+1  entries currently stored
busy  out  1  FIFO not empty, or wait count nonzero, or sid_we high

Behaviour:
- Reset (synchronous, active-high):
  - FIFO emptied; fifo_level=0; wait_cnt=0.
  - sid_we=0, sid_addr=0, sid_data=0.
  - Round-robin pointer set to favour A.
  - Reset mid-write or mid-delay drops all pending commands and takes effect at the next clk edge.
- Acceptance:
  - A transfer occurs when x_valid && x_ready in the same clk.
  - a_ready and b_ready are combinational.
  - Never both high in one cycle.
  - Both are 0 when the FIFO is full, even if a pop happens that same cycle.
- Arbitration:
  - Only one requester valid: it is granted.
  - Both valid: the requester not granted most recently wins; the pointer updates on each accepted transfer.
  - Neither valid: the pointer is unchanged.
- FIFO:
  - Entry is {addr, data}.
  - Push and pop in the same cycle leave fifo_level unchanged.
  - Pointers wrap modulo DEPTH.
  - fifo_level counts 0..DEPTH.
- Issue: the outputs sid_we, sid_addr and sid_data change only at the clk edge that ends a cycle with ce_1m=1. Each write is therefore held stable for one full SID cycle and sampled by the SID at the next ce_1m. At each ce_1m edge, the first matching rule applies:
  1. wait_cnt != 0: wait_cnt decrements, sid_we <= 0, no pop.
  2. FIFO not empty and head addr == DELAY_CMD (delay feature enabled): pop; wait_cnt <= head data; sid_we <= 0. A delay with count D idles D+1 SID slots in total. D=0 idles exactly one slot; D=255 idles 256 slots.
  3. FIFO not empty, normal entry: pop; sid_we <= 1; sid_addr/sid_data <= head.
  4. FIFO empty: sid_we <= 0; sid_addr/sid_data hold their previous values.
- Throughput and latency:
  - Back-to-back writes keep sid_we continuously high, with new addr/data each slot.
  - Minimum latency, push to sid_we high: the push is visible to the next ce_1m cycle, so sid_we rises at the edge ending that cycle.
  - A push in the same cycle as ce_1m is not visible to that ce_1m. It issues on the following ce_1m.
- ce_1m is never asserted in consecutive clks in this design; behaviour under such a condition is still one issue step per ce_1m cycle.

Optional Feature:
- Macro SIDSCHED_DELAY_CMD_EN.
- Defined: rule 2 is active; delay entries never reach the SID.
- Undefined: no wait_cnt logic. Entries with addr DELAY_CMD are popped and discarded silently, taking one slot with sid_we=0.
- In both cases no SID write to addr 5'h1F ever occurs.

Test Plan:
- Reset, then A pushes {5'h18, 8'h0F} → a_ready=1 that cycle. At the first ce_1m edge after the push: sid_we=1, sid_addr=18, sid_data=0F. At the next ce_1m edge: sid_we=0. fifo_level sequence 0,1,0.
- A and B both valid continuously with distinct data, FIFO draining → accepted order A,B,A,B…. Never both ready in one cycle. SID writes appear in the same alternating order, one per ce_1m.
- Fill 8 entries with no ce_1m → fifo_level=8 and a_ready=b_ready=0. Assert ce_1m with a_valid=1 in the same clk → no push that cycle. Push accepted the cycle after.
- Delay feature on: push {1F,03} then {00,AA} → 4 ce_1m slots with sid_we=0, then a write 00=AA in the 5th slot. With the macro undefined: 1 idle slot, then the write.
- Mid-delay (wait_cnt=2) with 3 entries queued, pulse reset=1 for one clk → next cycle: fifo_level=0, sid_we=0, busy=0. No further writes.
- Push exactly on a ce_1m cycle with the FIFO empty → sid_we stays 0 at that edge and goes to 1 at the next ce_1m edge, 12 clks later.
